tipi_rpi_link: RTL

- Host-side serial link master that drives the TIPI CPLD's RPi-facing shift-register interface (r_clk, r_le, r_dc, r_rt, r_dout, r_din). It replaces GPIO bit-banging.
- Converts one-byte transfer commands into the exact pin sequence the CPLD shift stages expect:
  - Reads: TD/TC latched by the TI.
  - Writes: RD/RC registers read by the TI.
- Sits directly downstream of the CPLD shift registers, on an FPGA beside the RPi.

---
 rtl/tipi_link_pkg.sv | 22 ++
 rtl/tipi_sync.sv | 21 ++
 rtl/tipi_rpi_link.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tipi_link_pkg.sv
// Shared types and constants for the TIPI RPi-side shift-register link master.
package tipi_link_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        LOAD_HI,
        LOAD_LO,
        CLK_LO,
        CLK_HI,
        LATCH_HI,
        LATCH_LO,
        DONE
    } state_e;

    localparam int   BYTE_BITS = 8;
    localparam logic RT_TI     = 1'b1;  // byte originates at the TI (TD/TC)
    localparam logic RT_RPI    = 1'b0;  // byte destined for the TI (RD/RC)
    localparam logic DC_CTRL   = 1'b1;
    localparam logic DC_DATA   = 1'b0;

endpackage

// File: rtl/tipi_sync.sv
// Multi-flop synchronizer for asynchronous single-bit inputs from the CPLD.
module tipi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the flop chain; the oldest stage is the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= (sync_q << 1) | STAGES'(d_i);
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tipi_rpi_link.sv
// Link master: turns one-byte transfer commands into the r_clk/r_le/r_rt/r_dc/
// r_dout pin sequence of the TIPI CPLD shift stages. All pins come from flops.
module tipi_rpi_link
    import tipi_link_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rt,
    input  logic       cmd_dc,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_abort,
    output logic       r_clk,
    output logic       r_le,
    output logic       r_rt,
    output logic       r_dc,
    output logic       r_dout,
    input  logic       r_din,
    input  logic       ti_reset
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic       rt_q, rt_d, dc_q, dc_d;
    logic [7:0] data_q, data_d, rdat_q, rdat_d;
    logic       ready_q, ready_d, vld_q, vld_d, abrt_q, abrt_d;
    logic       clk_q, clk_d, le_q, le_d, prt_q, prt_d, pdc_q, pdc_d, dout_q, dout_d;
    logic       din_s, tir_s;
    logic       accept, last, abort, active;

    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk(clk), .reset(reset), .d_i(r_din), .q_o(din_s)
    );
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_tir (
        .clk(clk), .reset(reset), .d_i(ti_reset), .q_o(tir_s)
    );

    assign cmd_ready = ready_q && !tir_s;
    assign accept    = cmd_valid && cmd_ready;
    assign last      = (cnt_q == 8'(CLK_DIV - 1));
    // A ti_reset arriving in DONE lets that transaction finish normally.
    assign abort     = tir_s && (state_q != IDLE) && (state_q != DONE);

    // Phase sequencing, command capture, read-bit capture and next pin levels.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rt_d    = rt_q;
        dc_d    = dc_q;
        data_d  = data_q;
        rdat_d  = rdat_q;
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = SETUP;
                rt_d    = cmd_rt;
                dc_d    = cmd_dc;
                data_d  = cmd_data;
                rdat_d  = '0;
                bit_d   = '0;
            end
            SETUP:    if (last) state_d = (rt_q == RT_TI) ? LOAD_HI : CLK_LO;
            LOAD_HI:  if (last) state_d = LOAD_LO;
            LOAD_LO:  if (last) state_d = CLK_LO;
            CLK_LO: if (last) begin
                state_d = CLK_HI;
                // Sample at the end of the low phase, well after the previous rise.
                if (rt_q == RT_TI) rdat_d = {rdat_q[6:0], din_s};
            end
            CLK_HI: if (last) begin
                bit_d  = bit_q + 3'd1;
                data_d = {data_q[6:0], 1'b0};
                if (bit_q == 3'(BYTE_BITS - 1)) state_d = (rt_q == RT_TI) ? DONE : LATCH_HI;
                else                            state_d = CLK_LO;
            end
            LATCH_HI: if (last) state_d = LATCH_LO;
            LATCH_LO: if (last) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort) begin
            state_d = DONE;
            rdat_d  = '0;
        end

        cnt_d = (state_d != state_q || state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;

        active  = (state_d != IDLE) && (state_d != DONE);
        clk_d   = (state_d == CLK_HI);
        le_d    = (state_d == LOAD_HI) || (state_d == LATCH_HI);
        prt_d   = active && rt_d;
        pdc_d   = active && dc_d;
        // r_dout only moves when a low phase starts, never with a rising r_clk.
        dout_d  = dout_q;
        if (!active)
            dout_d = 1'b0;
        else if (state_d == CLK_LO && state_q != CLK_LO && rt_d == RT_RPI)
            dout_d = data_d[7];

        ready_d = (state_d == IDLE);
        vld_d   = (state_d == DONE);
        abrt_d  = abort;
    end

    // State, datapath and pin registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            rt_q    <= 1'b0;
            dc_q    <= 1'b0;
            data_q  <= '0;
            rdat_q  <= '0;
            ready_q <= 1'b0;
            vld_q   <= 1'b0;
            abrt_q  <= 1'b0;
            clk_q   <= 1'b0;
            le_q    <= 1'b0;
            prt_q   <= 1'b0;
            pdc_q   <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            rt_q    <= rt_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
            rdat_q  <= rdat_d;
            ready_q <= ready_d;
            vld_q   <= vld_d;
            abrt_q  <= abrt_d;
            clk_q   <= clk_d;
            le_q    <= le_d;
            prt_q   <= prt_d;
            pdc_q   <= pdc_d;
            dout_q  <= dout_d;
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_data  = rdat_q;
    assign rsp_abort = abrt_q;
    assign r_clk     = clk_q;
    assign r_le      = le_q;
    assign r_rt      = prt_q;
    assign r_dc      = pdc_q;
    assign r_dout    = dout_q;

endmodule
